// File: rtl/sle_seq_ctrl_if.sv
// Request/completion bundle between the two requesters and the SLE sequencer.
// Requester fields are packed two-wide; bit/slice i belongs to requester i.
interface sle_seq_ctrl_if #(
  parameter int CNT_W = 8
);
  logic [1:0]         req_valid;
  logic [3:0]         req_op;
  logic [1:0]         req_val;
  logic [2*CNT_W-1:0] req_len;
  logic [1:0]         req_ready;
  logic               busy;
  logic               done;
  logic               done_id;

  modport master (
    output req_valid, req_op, req_val, req_len,
    input  req_ready, busy, done, done_id
  );

  modport slave (
    input  req_valid, req_op, req_val, req_len,
    output req_ready, busy, done, done_id
  );
endinterface

// File: rtl/sle_seq_ctrl.sv
// Round-robin sequencer driving one SLE cell in flip-flop mode: async load,
// sync set, timed capture or no-op, with a one-cycle done pulse per command.
module sle_seq_ctrl #(
  parameter int ALN_CYC = 2,
  parameter int CNT_W   = 8
) (
  input  logic           clk,
  input  logic           rst,
  sle_seq_ctrl_if.slave  bus,
  output logic           sle_aln,
  output logic           sle_adn,
  output logic           sle_en,
  output logic           sle_sln,
  output logic           sle_sd,
  output logic           sle_lat
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ALOAD = 3'd1,
    S_SLOAD = 3'd2,
    S_CAPT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [1:0]       OP_NOP   = 2'b00;
  localparam logic [1:0]       OP_ALOAD = 2'b01;
  localparam logic [1:0]       OP_SLOAD = 2'b10;
  localparam logic [1:0]       OP_CAPT  = 2'b11;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] ALN_LAST = CNT_W'(ALN_CYC - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             id_q, id_d;
  logic             ptr_q, ptr_d;
  logic             done_q, done_d;
  logic             done_id_q, done_id_d;
  logic             aln_q, aln_d;
  logic             adn_q, adn_d;
  logic             en_q, en_d;
  logic             sln_q, sln_d;
  logic             sd_q, sd_d;

  logic [1:0]       grant_s;
  logic             sel_s;
  logic [1:0]       op_s;
  logic             val_s;
  logic [CNT_W-1:0] len_s;

  // ptr_q names the requester served last; on a tie the other one wins.
  always_comb begin
    grant_s = 2'b00;
    if ((state_q == S_IDLE) && !rst) begin
      if (bus.req_valid[0] && (!bus.req_valid[1] || ptr_q)) begin
        grant_s = 2'b01;
      end else if (bus.req_valid[1]) begin
        grant_s = 2'b10;
      end else begin
        grant_s = 2'b00;
      end
    end else begin
      grant_s = 2'b00;
    end
  end

  assign sel_s = grant_s[1];
  assign op_s  = sel_s ? bus.req_op[3:2] : bus.req_op[1:0];
  assign val_s = sel_s ? bus.req_val[1]  : bus.req_val[0];
  assign len_s = sel_s ? bus.req_len[2*CNT_W-1:CNT_W] : bus.req_len[CNT_W-1:0];

  // Next-state and next-pin computation; pins default to their idle values.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    id_d      = id_q;
    ptr_d     = ptr_q;
    done_d    = 1'b0;
    done_id_d = 1'b0;
    aln_d     = 1'b1;
    adn_d     = 1'b1;
    en_d      = 1'b0;
    sln_d     = 1'b0;
    sd_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (grant_s != 2'b00) begin
          id_d = sel_s;
          case (op_s)
            OP_ALOAD: begin
              state_d = S_ALOAD;
              cnt_d   = ALN_LAST;
              aln_d   = 1'b0;
              adn_d   = ~val_s;
            end
            OP_SLOAD: begin
              state_d = S_SLOAD;
              en_d    = 1'b1;
              sd_d    = val_s;
            end
            OP_CAPT: begin
              if (len_s == CNT_ZERO) begin
                state_d   = S_DONE;
                done_d    = 1'b1;
                done_id_d = sel_s;
              end else begin
                state_d = S_CAPT;
                cnt_d   = len_s - CNT_ONE;
                en_d    = 1'b1;
                sln_d   = 1'b1;
              end
            end
            OP_NOP: begin
              state_d   = S_DONE;
              done_d    = 1'b1;
              done_id_d = sel_s;
            end
            default: begin
              state_d   = S_DONE;
              done_d    = 1'b1;
              done_id_d = sel_s;
            end
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ALOAD: begin
        if (cnt_q == CNT_ZERO) begin
          state_d   = S_DONE;
          done_d    = 1'b1;
          done_id_d = id_q;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
          aln_d = 1'b0;
          adn_d = adn_q;
        end
      end
      S_SLOAD: begin
        state_d   = S_DONE;
        done_d    = 1'b1;
        done_id_d = id_q;
      end
      S_CAPT: begin
        if (cnt_q == CNT_ZERO) begin
          state_d   = S_DONE;
          done_d    = 1'b1;
          done_id_d = id_q;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
          en_d  = 1'b1;
          sln_d = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        ptr_d   = id_q;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // All state and cell pins are flops so the cell never sees an input glitch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= CNT_ZERO;
      id_q      <= 1'b0;
      ptr_q     <= 1'b1;
      done_q    <= 1'b0;
      done_id_q <= 1'b0;
      aln_q     <= 1'b1;
      adn_q     <= 1'b1;
      en_q      <= 1'b0;
      sln_q     <= 1'b0;
      sd_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      id_q      <= id_d;
      ptr_q     <= ptr_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      aln_q     <= aln_d;
      adn_q     <= adn_d;
      en_q      <= en_d;
      sln_q     <= sln_d;
      sd_q      <= sd_d;
    end
  end

  assign bus.req_ready = grant_s;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = done_q;
  assign bus.done_id   = done_id_q;
  assign sle_aln       = aln_q;
  assign sle_adn       = adn_q;
  assign sle_en        = en_q;
  assign sle_sln       = sln_q;
  assign sle_sd        = sd_q;
  assign sle_lat       = 1'b0;

endmodule

// File: tb/tb_sle_seq_ctrl.sv
// Directed bench for sle_seq_ctrl: instance A (ALN_CYC=2) drives a behavioural
// SLE cell; instance B (ALN_CYC=4) is used for the mid-load reset case.
module tb_sle_seq_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic d   = 1'b0;
  logic q_cell;

  logic a_aln, a_adn, a_en, a_sln, a_sd, a_lat;
  logic b_aln, b_adn, b_en, b_sln, b_sd, b_lat;

  int checks = 0;
  int errors = 0;

  sle_seq_ctrl_if #(.CNT_W(8)) ia ();
  sle_seq_ctrl_if #(.CNT_W(8)) ib ();

  sle_seq_ctrl #(.ALN_CYC(2), .CNT_W(8)) u_dut_a (
    .clk(clk), .rst(rst), .bus(ia),
    .sle_aln(a_aln), .sle_adn(a_adn), .sle_en(a_en),
    .sle_sln(a_sln), .sle_sd(a_sd), .sle_lat(a_lat)
  );

  sle_seq_ctrl #(.ALN_CYC(4), .CNT_W(8)) u_dut_b (
    .clk(clk), .rst(rst), .bus(ib),
    .sle_aln(b_aln), .sle_adn(b_adn), .sle_en(b_en),
    .sle_sln(b_sln), .sle_sd(b_sd), .sle_lat(b_lat)
  );

  always #5 clk = ~clk;

  // Behavioural SLE in flip-flop mode: aln/adn async load, en/sln/sd sync path.
  always @(posedge clk or negedge a_aln) begin
    if (!a_aln) q_cell <= ~a_adn;
    else if (a_en) q_cell <= a_sln ? d : a_sd;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  logic exp_q;

  initial begin
    ia.req_valid = 2'b00; ia.req_op = 4'b0000; ia.req_val = 2'b00; ia.req_len = 16'h0000;
    ib.req_valid = 2'b00; ib.req_op = 4'b0000; ib.req_val = 2'b00; ib.req_len = 16'h0000;
    #1 rst = 1'b1;

    // Reset state, with a request already pending
    nxt();
    ia.req_valid = 2'b01;
    #1;
    chk("rst_ready", ia.req_ready, 2'b00);
    chk("rst_busy", ia.busy, 1'b0);
    chk("rst_done", ia.done, 1'b0);
    chk("rst_done_id", ia.done_id, 1'b0);
    chk("rst_pins", {a_aln, a_adn, a_en, a_sln, a_sd, a_lat}, 6'b110000);
    ia.req_valid = 2'b00;
    nxt();
    rst = 1'b0;

    // Requester 0 ALOAD val=1, ALN_CYC=2
    nxt();
    ia.req_valid = 2'b01; ia.req_op = 4'b0001; ia.req_val = 2'b01;
    #1;
    chk("aload_ready", ia.req_ready, 2'b01);
    nxt();
    ia.req_valid = 2'b00;
    #1;
    chk("aload_t1_pins", {a_aln, a_adn, ia.busy, ia.req_ready}, 5'b00100);
    nxt();
    chk("aload_t2_pins", {a_aln, a_adn, ia.done}, 3'b000);
    nxt();
    chk("aload_done", {ia.done, ia.done_id, a_aln, a_adn}, 4'b1011);
    chk("aload_q", q_cell, 1'b1);
    nxt();
    chk("aload_after", {ia.done, ia.busy}, 2'b00);

    // Requester 1 SLOAD val=0
    ia.req_valid = 2'b10; ia.req_op = 4'b1000; ia.req_val = 2'b00;
    #1;
    chk("sload_ready", ia.req_ready, 2'b10);
    nxt();
    ia.req_valid = 2'b00;
    chk("sload_t1_pins", {a_en, a_sln, a_sd, a_aln}, 4'b1001);
    nxt();
    chk("sload_done", {ia.done, ia.done_id, a_en}, 3'b110);
    chk("sload_q", q_cell, 1'b0);
    nxt();
    chk("sload_after", ia.done, 1'b0);

    // Requester 0 CAPT len=5 with d toggling every cycle
    d = 1'b0;
    exp_q = 1'b0;
    ia.req_valid = 2'b01; ia.req_op = 4'b0011; ia.req_len = 16'h0005;
    #1;
    chk("capt_ready", ia.req_ready, 2'b01);
    for (int i = 1; i <= 5; i++) begin
      nxt();
      ia.req_valid = 2'b00;
      chk($sformatf("capt_t%0d_pins", i), {a_en, a_sln, ia.done}, 3'b110);
      chk($sformatf("capt_t%0d_q", i), q_cell, exp_q);
      d = ~d;
      exp_q = d;
    end
    nxt();
    chk("capt_done", {ia.done, ia.done_id, a_en, a_sln}, 4'b1000);
    chk("capt_q_last", q_cell, exp_q);
    d = ~d;
    nxt();
    chk("capt_q_hold", q_cell, exp_q);

    // Requester 1 CAPT len=0 completes immediately, en never asserts
    ia.req_valid = 2'b10; ia.req_op = 4'b1100; ia.req_len = 16'h0000;
    #1;
    chk("capt0_ready", ia.req_ready, 2'b10);
    nxt();
    ia.req_valid = 2'b00;
    chk("capt0_done", {ia.done, ia.done_id, a_en, ia.busy}, 4'b1101);
    nxt();
    chk("capt0_after", {ia.done, ia.busy, a_en}, 3'b000);

    // Both valid with NOPs: grants alternate 0,1,0,1
    ia.req_valid = 2'b11; ia.req_op = 4'b0000;
    for (int g = 0; g < 4; g++) begin
      #1;
      chk($sformatf("rr%0d_ready", g), ia.req_ready, (g % 2 == 0) ? 2'b01 : 2'b10);
      nxt();
      chk($sformatf("rr%0d_done", g), {ia.done, ia.done_id, ia.busy, ia.req_ready},
          {1'b1, (g % 2 == 1), 1'b1, 2'b00});
      nxt();
    end
    ia.req_valid = 2'b00;

    // Instance B: reset lands in the middle of an ALOAD (ALN_CYC=4)
    ib.req_valid = 2'b01; ib.req_op = 4'b0001; ib.req_val = 2'b01;
    #1;
    chk("b_aload_ready", ib.req_ready, 2'b01);
    nxt();
    ib.req_valid = 2'b10; ib.req_op = 4'b1001; ib.req_val = 2'b10;
    chk("b_aload_t1", {b_aln, b_adn, ib.req_ready}, 4'b0000);
    nxt();
    chk("b_aload_t2", {b_aln, b_adn}, 2'b00);
    #1 rst = 1'b1;
    #1;
    chk("b_rst_pins", {b_aln, b_adn, b_en, b_sln, b_sd, b_lat}, 6'b110000);
    chk("b_rst_status", {ib.busy, ib.done, ib.req_ready}, 4'b0000);
    for (int k = 0; k < 3; k++) begin
      nxt();
      chk($sformatf("b_rst_nodone%0d", k), {ib.done, b_aln}, 2'b01);
    end
    rst = 1'b0;
    #1;
    chk("b_post_ready", ib.req_ready, 2'b10);
    nxt();
    ib.req_valid = 2'b00;
    chk("b_post_sload", {b_en, b_sln, b_sd, ib.done}, 4'b1010);
    nxt();
    chk("b_post_done", {ib.done, ib.done_id}, 2'b11);
    nxt();
    chk("b_post_idle", {ib.done, ib.busy}, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
